// File: rtl/spi_to_axis_mux.sv
// spi_to_axis_mux
// Merges N_CH SPI receiver word streams round-robin into one shared
// first-word-fall-through FIFO and emits channel-tagged AXI4-Stream packets
// of programmable length, with sticky overflow and saturating drop counting.

module spi_to_axis_mux #(
   parameter int DATA_WIDTH = 32,
   parameter int N_CH       = 4,
   parameter int CH_W       = 2,
   parameter int FIFO_DEPTH = 16,
   parameter int PKT_LEN_W  = 10,
   parameter int KEEP_WIDTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_enable,
   input  logic [PKT_LEN_W-1:0]       i_pkt_len,
   input  logic                       i_clr_stat,
   input  logic [N_CH-1:0]            i_DV,
   input  logic [N_CH*DATA_WIDTH-1:0] i_data,
   output logic [N_CH-1:0]            o_fifo_en,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tvalid,
   output logic [DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
   output logic [CH_W-1:0]            m_axis_tuser,
   output logic                       m_axis_tlast,
   output logic [PKT_LEN_W-1:0]       o_counter,
   output logic [CNT_W-1:0]           o_drop_cnt,
   output logic                       o_overflow,
   output logic [1:0]                 o_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t                 state;
   logic [PKT_LEN_W-1:0]   plen;
   logic [PKT_LEN_W-1:0]   counter;
   logic [PKT_LEN_W-1:0]   plen_in;

   logic [DATA_WIDTH-1:0]  hold_data [N_CH];
   logic [N_CH-1:0]        hold_full;
   logic                   holds_empty;

   logic [CH_W-1:0]        rr_ptr;
   logic [N_CH-1:0]        grant;
   logic                   grant_valid;
   logic [CH_W-1:0]        grant_ch;
   logic [DATA_WIDTH-1:0]  grant_data;

   logic [DATA_WIDTH-1:0]  mem_data [FIFO_DEPTH];
   logic [CH_W-1:0]        mem_ch   [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [AW:0]            fifo_cnt;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   wr_en;
   logic                   rd_en;
   logic                   tlast_raw;

   logic [N_CH-1:0]        load;
   logic [4:0]             drop_num;
   logic [CNT_W-1:0]       drop_base;
   logic [CNT_W:0]         drop_sum;
   logic [CNT_W-1:0]       drop_next;

   assign plen_in     = (i_pkt_len == '0) ? PKT_LEN_W'(1) : i_pkt_len;
   assign holds_empty = ~|hold_full;
   assign fifo_full   = (fifo_cnt == FULL_CNT);
   assign fifo_empty  = (fifo_cnt == '0);
   assign wr_en       = grant_valid;
   assign rd_en       = m_axis_tvalid && m_axis_tready;

   // Round-robin search: first full holding register at or above the pointer, then wrap
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      grant_ch    = '0;
      grant_data  = '0;
      if (!fifo_full) begin
         for (int c = 0; c < N_CH; c++) begin
            if (!grant_valid && hold_full[c] && (CH_W'(c) >= rr_ptr)) begin
               grant_valid = 1'b1;
               grant_ch    = CH_W'(c);
               grant[c]    = 1'b1;
               grant_data  = hold_data[c];
            end
         end
         for (int c = 0; c < N_CH; c++) begin
            if (!grant_valid && hold_full[c]) begin
               grant_valid = 1'b1;
               grant_ch    = CH_W'(c);
               grant[c]    = 1'b1;
               grant_data  = hold_data[c];
            end
         end
      end
   end

   // Decide per channel whether a strobed word is captured or dropped
   always_comb begin
      load     = '0;
      drop_num = '0;
      if (state == RUN) begin
         for (int c = 0; c < N_CH; c++) begin
            if (i_DV[c]) begin
               if (!hold_full[c] || grant[c]) begin
                  load[c] = 1'b1;
               end else begin
                  drop_num = drop_num + 5'd1;
               end
            end
         end
      end
   end

   // Next drop count: a clear restarts from zero, drops in the same cycle still count
   always_comb begin
      drop_base = i_clr_stat ? '0 : o_drop_cnt;
      drop_sum  = {1'b0, drop_base} + (CNT_W+1)'(drop_num);
      drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
   end

   // Holding registers: capture on strobe, release when the arbiter grants them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_full <= '0;
         for (int c = 0; c < N_CH; c++) begin
            hold_data[c] <= '0;
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (load[c]) begin
               hold_data[c] <= i_data[c*DATA_WIDTH +: DATA_WIDTH];
               hold_full[c] <= 1'b1;
            end else if (grant[c]) begin
               hold_full[c] <= 1'b0;
            end
         end
      end
   end

   // Advance the round-robin pointer past the channel just granted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (grant_valid) begin
         rr_ptr <= (grant_ch == LAST_CH) ? '0 : grant_ch + CH_W'(1);
      end
   end

   // FIFO storage array, written with the granted word and its channel tag
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data[wr_ptr] <= grant_data;
         mem_ch[wr_ptr]   <= grant_ch;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Control FSM plus packet length latch and beat counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         plen    <= PKT_LEN_W'(1);
         counter <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_enable) begin
                  plen  <= plen_in;
                  state <= RUN;
               end
            end
            RUN: begin
               if (!i_enable) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if (fifo_empty && holds_empty && (counter == '0)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (rd_en) begin
            if (m_axis_tlast) begin
               counter <= '0;
               plen    <= plen_in;
            end else begin
               counter <= counter + PKT_LEN_W'(1);
            end
         end
      end
   end

   // Sticky overflow flag and saturating drop counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_drop_cnt <= '0;
         o_overflow <= 1'b0;
      end else begin
         o_drop_cnt <= drop_next;
         if (drop_num != '0) begin
            o_overflow <= 1'b1;
         end else if (i_clr_stat) begin
            o_overflow <= 1'b0;
         end
      end
   end

   assign tlast_raw = (counter == plen - PKT_LEN_W'(1)) ||
                      ((state == FLUSH) && (fifo_cnt == (AW+1)'(1)) && holds_empty && !grant_valid);

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = m_axis_tvalid ? mem_data[rd_ptr] : '0;
   assign m_axis_tuser  = m_axis_tvalid ? mem_ch[rd_ptr]   : '0;
   assign m_axis_tkeep  = m_axis_tvalid ? '1 : '0;
   assign m_axis_tlast  = m_axis_tvalid && tlast_raw;
   assign o_fifo_en     = (state == RUN) ? ~hold_full : '0;
   assign o_counter     = counter;
   assign o_state       = state;

endmodule

// File: tb/tb_spi_to_axis_mux.sv
// Testbench for spi_to_axis_mux: scoreboard of expected beats filled at
// stimulus time and drained by a monitor on each stream transfer.

module tb_spi_to_axis_mux;

   localparam int DW  = 32;
   localparam int NCH = 4;
   localparam int CHW = 2;
   localparam int PLW = 10;
   localparam int KW  = 4;
   localparam int CW  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_enable = 1'b0;
   logic [PLW-1:0]    i_pkt_len = '0;
   logic              i_clr_stat = 1'b0;
   logic [NCH-1:0]    i_DV = '0;
   logic [NCH*DW-1:0] i_data = '0;
   logic [NCH-1:0]    o_fifo_en;
   logic              m_axis_tready = 1'b0;
   logic              m_axis_tvalid;
   logic [DW-1:0]     m_axis_tdata;
   logic [KW-1:0]     m_axis_tkeep;
   logic [CHW-1:0]    m_axis_tuser;
   logic              m_axis_tlast;
   logic [PLW-1:0]    o_counter;
   logic [CW-1:0]     o_drop_cnt;
   logic              o_overflow;
   logic [1:0]        o_state;

   typedef struct packed {
      logic [CHW-1:0] ch;
      logic [DW-1:0]  data;
      logic           last;
   } beat_t;

   beat_t sb[$];
   int    checks = 0;
   int    errors = 0;

   spi_to_axis_mux dut (
      .clk           (clk),
      .rst           (rst),
      .i_enable      (i_enable),
      .i_pkt_len     (i_pkt_len),
      .i_clr_stat    (i_clr_stat),
      .i_DV          (i_DV),
      .i_data        (i_data),
      .o_fifo_en     (o_fifo_en),
      .m_axis_tready (m_axis_tready),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .o_counter     (o_counter),
      .o_drop_cnt    (o_drop_cnt),
      .o_overflow    (o_overflow),
      .o_state       (o_state)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Strobe the channels in mask for one edge; channel c carries base+c
   task automatic applyStimulus(input logic [NCH-1:0] mask, input logic [DW-1:0] base,
                                input logic [NCH-1:0] last_mask, input bit push);
      beat_t b;
      for (int c = 0; c < NCH; c++) begin
         i_data[c*DW +: DW] = base + DW'(c);
         if (mask[c] && push) begin
            b.ch   = CHW'(c);
            b.data = base + DW'(c);
            b.last = last_mask[c];
            sb.push_back(b);
         end
      end
      i_DV = mask;
      tick(1);
      i_DV = '0;
   endtask

   task automatic doReset();
      rst           = 1'b1;
      i_enable      = 1'b0;
      i_DV          = '0;
      i_clr_stat    = 1'b0;
      m_axis_tready = 1'b0;
      i_pkt_len     = '0;
      sb.delete();
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic startRun(input logic [PLW-1:0] len);
      i_pkt_len = len;
      i_enable  = 1'b1;
      tick(1);
      checkOutput("run_state", 64'(o_state), 64'd1);
   endtask

   // Monitor: every stream transfer must match the oldest expected beat
   always @(negedge clk) begin : monitor_blk
      beat_t exp_b;
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         if (sb.size() == 0) begin
            checkOutput("sb_underflow", 64'(sb.size()), 64'd1);
         end else begin
            exp_b = sb.pop_front();
            checkOutput("tdata", 64'(m_axis_tdata), 64'(exp_b.data));
            checkOutput("tuser", 64'(m_axis_tuser), 64'(exp_b.ch));
            checkOutput("tlast", 64'(m_axis_tlast), 64'(exp_b.last));
            checkOutput("tkeep", 64'(m_axis_tkeep), 64'hF);
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence
   initial begin
      tick(2);
      rst = 1'b0;
      tick(1);
      checkOutput("rst_tvalid",  64'(m_axis_tvalid), 64'd0);
      checkOutput("rst_tdata",   64'(m_axis_tdata),  64'd0);
      checkOutput("rst_tkeep",   64'(m_axis_tkeep),  64'd0);
      checkOutput("rst_tuser",   64'(m_axis_tuser),  64'd0);
      checkOutput("rst_tlast",   64'(m_axis_tlast),  64'd0);
      checkOutput("rst_counter", 64'(o_counter),     64'd0);
      checkOutput("rst_drop",    64'(o_drop_cnt),    64'd0);
      checkOutput("rst_ovf",     64'(o_overflow),    64'd0);
      checkOutput("rst_state",   64'(o_state),       64'd0);
      checkOutput("rst_fifo_en", 64'(o_fifo_en),     64'd0);

      // Single channel, 4-beat packets, latency check
      doReset();
      m_axis_tready = 1'b1;
      startRun(10'd4);
      checkOutput("t1_fifo_en", 64'(o_fifo_en), 64'hF);
      applyStimulus(4'b0001, 32'h444, 4'b0000, 1'b1);
      checkOutput("t1_lat_k", 64'(m_axis_tvalid), 64'd0);
      tick(1);
      checkOutput("t1_lat_k1", 64'(m_axis_tvalid), 64'd1);
      checkOutput("t1_cnt0",   64'(o_counter),     64'd0);
      tick(10);
      for (int n = 1; n < 4; n++) begin
         applyStimulus(4'b0001, 32'h444 + DW'(n), (n == 3) ? 4'b0001 : 4'b0000, 1'b1);
         tick(11);
      end
      checkOutput("t1_cnt_end", 64'(o_counter), 64'd0);
      checkOutput("t1_sb",      64'(sb.size()), 64'd0);

      // All channels at once, round-robin order and pointer wrap
      doReset();
      m_axis_tready = 1'b1;
      startRun(10'd8);
      applyStimulus(4'b1111, 32'hC0, 4'b0000, 1'b1);
      tick(6);
      applyStimulus(4'b1111, 32'hD0, 4'b1000, 1'b1);
      tick(8);
      checkOutput("t2_drop", 64'(o_drop_cnt), 64'd0);
      checkOutput("t2_cnt",  64'(o_counter),  64'd0);
      checkOutput("t2_sb",   64'(sb.size()),  64'd0);

      // Backpressure: fill FIFO and holding register, count drops
      doReset();
      startRun(10'd4);
      for (int n = 0; n < 20; n++) begin
         applyStimulus(4'b0001, 32'h300 + DW'(n), ((n % 4) == 3) ? 4'b0001 : 4'b0000, n < 17);
      end
      checkOutput("t3_drop3",   64'(o_drop_cnt),   64'd3);
      checkOutput("t3_ovf",     64'(o_overflow),   64'd1);
      checkOutput("t3_hold0",   64'(o_fifo_en[0]), 64'd0);
      checkOutput("t3_stall",   64'(m_axis_tdata), 64'h300);
      i_clr_stat = 1'b1;
      applyStimulus(4'b0001, 32'h3FF, 4'b0000, 1'b0);
      i_clr_stat = 1'b0;
      checkOutput("t3_clr_drop", 64'(o_drop_cnt), 64'd1);
      checkOutput("t3_clr_ovf",  64'(o_overflow), 64'd1);
      i_clr_stat = 1'b1;
      tick(1);
      i_clr_stat = 1'b0;
      checkOutput("t3_clr2_drop", 64'(o_drop_cnt), 64'd0);
      checkOutput("t3_clr2_ovf",  64'(o_overflow), 64'd0);
      m_axis_tready = 1'b1;
      for (int n = 0; n < 17; n++) begin
         @(negedge clk);
         checkOutput("t3_nogap", 64'(m_axis_tvalid), 64'd1);
      end
      @(negedge clk);
      checkOutput("t3_drained", 64'(m_axis_tvalid), 64'd0);
      tick(1);
      checkOutput("t3_sb", 64'(sb.size()), 64'd0);

      // FLUSH ends a short packet with tlast, then IDLE ignores strobes
      doReset();
      startRun(10'd5);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(4'b0001, 32'h400 + DW'(n), (n == 2) ? 4'b0001 : 4'b0000, 1'b1);
      end
      tick(3);
      i_enable = 1'b0;
      tick(1);
      checkOutput("t4_flush",   64'(o_state),   64'd2);
      checkOutput("t4_fifo_en", 64'(o_fifo_en), 64'd0);
      i_enable = 1'b1;
      applyStimulus(4'b0010, 32'hBAC, 4'b0000, 1'b0);
      i_enable = 1'b0;
      checkOutput("t4_still_flush", 64'(o_state), 64'd2);
      m_axis_tready = 1'b1;
      for (int i = 0; i < 30 && o_state != 2'd0; i++) begin
         tick(1);
      end
      checkOutput("t4_idle", 64'(o_state), 64'd0);
      checkOutput("t4_sb",   64'(sb.size()), 64'd0);
      applyStimulus(4'b0001, 32'h777, 4'b0000, 1'b0);
      tick(4);
      checkOutput("t4_ign_tvalid", 64'(m_axis_tvalid), 64'd0);
      checkOutput("t4_ign_state",  64'(o_state),       64'd0);

      // Packet length change applies only at the next packet boundary
      doReset();
      m_axis_tready = 1'b1;
      startRun(10'd4);
      for (int n = 0; n < 8; n++) begin
         applyStimulus(4'b0001, 32'h500 + DW'(n),
                       ((n == 3) || (n == 5) || (n == 7)) ? 4'b0001 : 4'b0000, 1'b1);
         if (n == 1) begin
            tick(1);
            checkOutput("t5_cnt_beat2", 64'(o_counter), 64'd1);
            i_pkt_len = 10'd2;
            tick(2);
         end else begin
            tick(3);
         end
      end
      tick(2);
      checkOutput("t5_cnt", 64'(o_counter), 64'd0);
      checkOutput("t5_sb",  64'(sb.size()), 64'd0);

      // Asynchronous reset mid-packet
      doReset();
      startRun(10'd8);
      for (int n = 0; n < 7; n++) begin
         applyStimulus(4'b0001, 32'h600 + DW'(n), 4'b0000, n < 2);
      end
      tick(3);
      m_axis_tready = 1'b1;
      tick(2);
      m_axis_tready = 1'b0;
      checkOutput("t6_cnt_mid", 64'(o_counter), 64'd2);
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      checkOutput("t6_rst_tvalid",  64'(m_axis_tvalid), 64'd0);
      checkOutput("t6_rst_tdata",   64'(m_axis_tdata),  64'd0);
      checkOutput("t6_rst_tkeep",   64'(m_axis_tkeep),  64'd0);
      checkOutput("t6_rst_tuser",   64'(m_axis_tuser),  64'd0);
      checkOutput("t6_rst_counter", 64'(o_counter),     64'd0);
      checkOutput("t6_rst_state",   64'(o_state),       64'd0);
      tick(1);
      rst = 1'b0;
      tick(1);
      startRun(10'd8);
      m_axis_tready = 1'b1;
      applyStimulus(4'b0001, 32'h6AA, 4'b0000, 1'b1);
      tick(1);
      checkOutput("t6_tvalid",  64'(m_axis_tvalid), 64'd1);
      checkOutput("t6_counter", 64'(o_counter),     64'd0);
      checkOutput("t6_tlast",   64'(m_axis_tlast),  64'd0);
      tick(2);
      checkOutput("t6_sb", 64'(sb.size()), 64'd0);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
